// File: rtl/mem_copy_engine.sv
// Bus-master word copy engine: reads word_count words from src and writes them to dst, two cycles per word.
// Define MEM_COPY_FILL_EN to add a fill mode (one write per cycle of a captured constant).
module mem_copy_engine #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [CNT_W-1:0] i_word_count,
`ifdef MEM_COPY_FILL_EN
    input  logic             i_fill,
    input  logic [31:0]      i_fill_value,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_addr,
    output logic [31:0]      o_write_data,
    output logic             o_mem_write,
    input  logic [31:0]      i_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_src, r_dst, r_hold;
    logic [CNT_W-1:0] r_cnt, r_idx;
    logic [CNT_W-1:0] w_idx_inc;
    logic [31:0]      w_offset;
    logic             w_last, w_fill_req, w_fill_run;

`ifdef MEM_COPY_FILL_EN
    logic r_fill;
    assign w_fill_req = i_fill;
    assign w_fill_run = r_fill;
`else
    assign w_fill_req = 1'b0;
    assign w_fill_run = 1'b0;
`endif

    assign w_idx_inc = r_idx + CNT_W'(1);
    assign w_last    = (w_idx_inc == r_cnt);
    // Byte offset of word i; the adds below wrap modulo 2^32.
    assign w_offset  = {{(30-CNT_W){1'b0}}, r_idx, 2'b00};

    assign o_write_data = r_hold;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_addr      = 32'h0;
        o_mem_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_word_count == '0) w_next = S_DONE;
                    else if (w_fill_req)    w_next = S_WRITE;
                    else                    w_next = S_READ;
                end
            end
            S_READ: begin
                o_busy = 1'b1;
                o_addr = r_src + w_offset;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                o_busy      = 1'b1;
                o_addr      = r_dst + w_offset;
                o_mem_write = 1'b1;
                if (w_last)          w_next = S_DONE;
                else if (w_fill_run) w_next = S_WRITE;
                else                 w_next = S_READ;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src  <= 32'h0;
            r_dst  <= 32'h0;
            r_hold <= 32'h0;
            r_cnt  <= '0;
            r_idx  <= '0;
`ifdef MEM_COPY_FILL_EN
            r_fill <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src <= i_src_addr;
                        r_dst <= i_dst_addr;
                        r_cnt <= i_word_count;
                        r_idx <= '0;
`ifdef MEM_COPY_FILL_EN
                        r_fill <= i_fill;
                        // Fill data rides in the holding register; left alone for a zero-length request.
                        if (i_fill && i_word_count != '0) r_hold <= i_fill_value;
`endif
                    end
                end
                S_READ:  r_hold <= i_read_data;
                S_WRITE: r_idx  <= w_idx_inc;
                default: ;
            endcase
        end
    end

endmodule
